// File: rtl/cplx_result_collector.sv
// rtl/cplx_result_collector.sv - round/shift/saturate complex products into a small FIFO.
// afull is the only throttle on the upstream multiplier, which has no ready input.
module cplx_result_collector #(
  parameter int IN_W      = 48,
  parameter int OUT_W     = 18,
  parameter int SHIFT     = 17,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_u1_valid,
  input  logic signed [IN_W-1:0]  i_s48_R,
  input  logic signed [IN_W-1:0]  i_s48_I,
  output logic                    o_u1_afull,
  output logic                    o_u1_valid,
  input  logic                    i_u1_ready,
  output logic signed [OUT_W-1:0] o_s18_R,
  output logic signed [OUT_W-1:0] o_s18_I,
  output logic                    o_u1_sat,
  output logic                    o_u1_ovf,
  input  logic                    i_u1_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IN_W:0] ONE  = 1;
  localparam logic signed [IN_W:0] HALF = (ONE <<< SHIFT) >>> 1;
  localparam logic signed [IN_W:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [IN_W:0] MINV = -(ONE <<< (OUT_W - 1));

  // Returns {clipped, sample}; one extra bit of headroom keeps the rounding add exact.
  function automatic logic [OUT_W:0] rnd_sat(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    t = {x[IN_W-1], x};
    t = (t + HALF) >>> SHIFT;
    if (t > MAXV) return {1'b1, MAXV[OUT_W-1:0]};
    if (t < MINV) return {1'b1, MINV[OUT_W-1:0]};
    return {1'b0, t[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0]       rs_r, rs_i;
  logic                 q_valid, q_clip;
  logic [OUT_W-1:0]     q_r, q_i;
  logic [2*OUT_W-1:0]   mem [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ_nxt;
  logic [2*OUT_W-1:0]   head;
  logic                 full, empty, pop, push_ok, drop;

  always_comb begin
    rs_r = rnd_sat(i_s48_R);
    rs_i = rnd_sat(i_s48_I);
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && i_u1_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = q_valid && (!full || pop);
  assign drop    = q_valid && full && !pop;
  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop);
  assign occ_nxt = wr_nxt - rd_nxt;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign o_u1_valid = !empty;
  assign o_s18_R    = empty ? '0 : head[2*OUT_W-1:OUT_W];
  assign o_s18_I    = empty ? '0 : head[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid    <= 1'b0;
      q_clip     <= 1'b0;
      q_r        <= '0;
      q_i        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_u1_afull <= 1'b0;
      o_u1_sat   <= 1'b0;
      o_u1_ovf   <= 1'b0;
    end else begin
      q_valid    <= i_u1_valid;
      q_clip     <= rs_r[OUT_W] | rs_i[OUT_W];
      q_r        <= rs_r[OUT_W-1:0];
      q_i        <= rs_i[OUT_W-1:0];
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      o_u1_afull <= (occ_nxt >= (AW+1)'(DEPTH - AFULL_LVL));
      // A new event in the same cycle as clear keeps the flag set.
      o_u1_sat   <= (q_valid && q_clip) || (o_u1_sat && !i_u1_clr);
      o_u1_ovf   <= drop || (o_u1_ovf && !i_u1_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {q_r, q_i};
  end

endmodule

// File: tb/tb_cplx_result_collector.sv
// tb/tb_cplx_result_collector.sv - table vectors, corner sequences and random soak vs queue model.
module tb_cplx_result_collector;
  localparam int DEPTH = 4;
  localparam int AFULL_LVL = 2;
  localparam int SHIFT = 17;
  localparam int OUT_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_u1_valid = 1'b0;
  logic signed [47:0] i_s48_R = '0;
  logic signed [47:0] i_s48_I = '0;
  logic i_u1_ready = 1'b0;
  logic i_u1_clr = 1'b0;
  logic o_u1_afull, o_u1_valid, o_u1_sat, o_u1_ovf;
  logic signed [17:0] o_s18_R, o_s18_I;

  int cks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cplx_result_collector dut (
    .clk(clk), .rst(rst), .i_u1_valid(i_u1_valid), .i_s48_R(i_s48_R), .i_s48_I(i_s48_I),
    .o_u1_afull(o_u1_afull), .o_u1_valid(o_u1_valid), .i_u1_ready(i_u1_ready),
    .o_s18_R(o_s18_R), .o_s18_I(o_s18_I), .o_u1_sat(o_u1_sat), .o_u1_ovf(o_u1_ovf),
    .i_u1_clr(i_u1_clr)
  );

  // Reference: results as a FIFO queue of whole samples, plus one slot of pipeline delay.
  longint mq_r[$];
  longint mq_i[$];
  bit m_qv, m_qc, m_sat, m_ovf, m_afull;
  longint m_qr, m_qi;

  function automatic longint round_sat(input longint x, output bit clip);
    longint dv, q, res, lim;
    dv = 1;
    for (int k = 0; k < SHIFT; k++) dv = dv * 2;
    q = x + dv / 2;
    res = (q >= 0) ? q / dv : -((-q + dv - 1) / dv);
    lim = 1;
    for (int k = 0; k < OUT_W - 1; k++) lim = lim * 2;
    clip = 1'b0;
    if (res > lim - 1) begin res = lim - 1; clip = 1'b1; end
    if (res < -lim) begin res = -lim; clip = 1'b1; end
    return res;
  endfunction

  task automatic model_reset();
    mq_r.delete(); mq_i.delete();
    m_qv = 0; m_qc = 0; m_sat = 0; m_ovf = 0; m_afull = 0; m_qr = 0; m_qi = 0;
  endtask

  task automatic model_edge(input bit v, input longint r, input longint i, input bit rdy, input bit clr);
    bit pop, acc, c1, c2;
    pop = (mq_r.size() > 0) && rdy;
    acc = m_qv && ((mq_r.size() < DEPTH) || pop);
    m_sat = (m_qv && m_qc) ? 1'b1 : (clr ? 1'b0 : m_sat);
    m_ovf = (m_qv && !acc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (pop) begin void'(mq_r.pop_front()); void'(mq_i.pop_front()); end
    if (acc) begin mq_r.push_back(m_qr); mq_i.push_back(m_qi); end
    m_afull = (mq_r.size() >= DEPTH - AFULL_LVL);
    m_qv = v;
    m_qr = round_sat(r, c1);
    m_qi = round_sat(i, c2);
    m_qc = c1 | c2;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    cks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit ne;
    ne = mq_r.size() > 0;
    chk("m_valid", longint'(o_u1_valid), longint'(ne));
    chk("m_R", longint'(o_s18_R), ne ? mq_r[0] : 0);
    chk("m_I", longint'(o_s18_I), ne ? mq_i[0] : 0);
    chk("m_sat", longint'(o_u1_sat), longint'(m_sat));
    chk("m_ovf", longint'(o_u1_ovf), longint'(m_ovf));
    chk("m_afull", longint'(o_u1_afull), longint'(m_afull));
  endtask

  task automatic step(input bit v, input longint r, input longint i, input bit rdy, input bit clr);
    i_u1_valid = v; i_s48_R = r[47:0]; i_s48_I = i[47:0]; i_u1_ready = rdy; i_u1_clr = clr;
    @(posedge clk);
    model_edge(v, r, i, rdy, clr);
    #1;
    compare_model();
  endtask

  function automatic longint rand48();
    longint v;
    v = longint'({$urandom, $urandom});
    return (v <<< 16) >>> 16;
  endfunction

  function automatic longint rand_val();
    case ($urandom_range(0, 2))
      0: return rand48();
      1: return longint'($urandom_range(0, 1 << 20)) - (1 << 19);
      default: return longint'($urandom_range(0, 1 << 26)) * 1024 - (longint'(1) << 35);
    endcase
  endfunction

  typedef struct {
    longint r;
    longint i;
    longint er;
    longint ei;
    bit esat;
  } vec_t;

  initial begin
    #500us;
    $display("FAIL timeout actual running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    longint big;
    bit rv, rr;
    longint rx, ry;
    big = longint'(1) << 40;
    tbl[0] = '{131072, -131072, 1, -1, 1'b0};
    tbl[1] = '{65536, 65535, 1, 0, 1'b0};
    tbl[2] = '{-65536, -65537, 0, -1, 1'b0};
    tbl[3] = '{65535, -65536, 0, 0, 1'b0};
    tbl[4] = '{(longint'(1) << 47) - 1, 0, 131071, 0, 1'b1};
    tbl[5] = '{0, -(longint'(1) << 47), 0, -131072, 1'b1};
    tbl[6] = '{big, -big, 131071, -131072, 1'b1};
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(o_u1_valid), 0);
    chk("rst_R", longint'(o_s18_R), 0);
    chk("rst_I", longint'(o_s18_I), 0);
    chk("rst_afull", longint'(o_u1_afull), 0);
    chk("rst_sat", longint'(o_u1_sat), 0);
    chk("rst_ovf", longint'(o_u1_ovf), 0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 1, 1);
      step(1, tbl[k].r, tbl[k].i, 1, 0);
      chk("lat_n1_valid", longint'(o_u1_valid), 0);
      step(0, 0, 0, 1, 0);
      chk("tbl_valid", longint'(o_u1_valid), 1);
      chk("tbl_R", longint'(o_s18_R), tbl[k].er);
      chk("tbl_I", longint'(o_s18_I), tbl[k].ei);
      chk("tbl_sat", longint'(o_u1_sat), longint'(tbl[k].esat));
      step(0, 0, 0, 1, 0);
      chk("tbl_n3_valid", longint'(o_u1_valid), 0);
    end

    step(0, 0, 0, 1, 1);
    chk("clr_sat", longint'(o_u1_sat), 0);
    step(1, big, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("clr_vs_set_sat", longint'(o_u1_sat), 1);

    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, longint'(k) << 17, -(longint'(k) << 17), 0, 0);
      if (k == 2) chk("afull_after_1st", longint'(o_u1_afull), 0);
      if (k == 3) chk("afull_after_2nd", longint'(o_u1_afull), 1);
    end
    step(0, 0, 0, 0, 0);
    chk("drop_ovf", longint'(o_u1_ovf), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("order_valid", longint'(o_u1_valid), 1);
      chk("order_R", longint'(o_s18_R), k);
      chk("order_I", longint'(o_s18_I), -k);
      step(0, 0, 0, 1, 0);
    end
    chk("drained_valid", longint'(o_u1_valid), 0);

    step(0, 0, 0, 1, 1);
    for (int k = 1; k <= 5; k++) step(1, longint'(k) << 17, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("full_pp_ovf", longint'(o_u1_ovf), 0);
    chk("full_pp_afull", longint'(o_u1_afull), 1);
    for (int k = 2; k <= 5; k++) begin
      chk("full_pp_R", longint'(o_s18_R), k);
      step(0, 0, 0, 1, 0);
    end
    chk("full_pp_empty", longint'(o_u1_valid), 0);

    for (int n = 0; n < 2000; n++) begin
      rv = ($urandom_range(0, 3) != 0) && (!m_afull || ($urandom_range(0, 7) == 0));
      rr = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rx = rand_val();
      ry = rand_val();
      step(rv, rx, ry, rr, $urandom_range(0, 15) == 0);
    end

    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 6; k++) step(1, big, -big, 0, 0);
    #3;
    rst = 1'b1;
    i_u1_valid = 1'b0;
    #1;
    chk("arst_valid", longint'(o_u1_valid), 0);
    chk("arst_afull", longint'(o_u1_afull), 0);
    chk("arst_sat", longint'(o_u1_sat), 0);
    chk("arst_ovf", longint'(o_u1_ovf), 0);
    chk("arst_R", longint'(o_s18_R), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, longint'(3) << 17, -(longint'(3) << 17), 1, 0);
    chk("post_rst_n1", longint'(o_u1_valid), 0);
    step(0, 0, 0, 1, 0);
    chk("post_rst_valid", longint'(o_u1_valid), 1);
    chk("post_rst_R", longint'(o_s18_R), 3);
    chk("post_rst_I", longint'(o_s18_I), -3);
    step(0, 0, 0, 1, 0);
    chk("post_rst_n3", longint'(o_u1_valid), 0);

    $display("CHECKS %0d ERRORS %0d", cks, errs);
    $finish;
  end
endmodule
